fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch and PC-sequencing stage that sits directly upstream of `main_decoder`. It owns the program counter and fetches each instruction from instruction memory through a valid-handshake, so wait-state memories are supported. It holds the instruction stable for the decoder/datapath and presents it as a one-cycle execute window. From the decoder's `pc_jal`, `pc_jalr`, `branch` controls and the ALU's `zero`/result, it computes the next PC.

## Interface
- `XLEN`, 32, datapath/address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  fetch request; held high until `imem_rvalid`.
- `imem_addr`  out  XLEN  fetch address; equals `pc`, stable while `imem_req`=1.
- `imem_rvalid`  in  1  instruction-memory data valid; sampled only in FETCH.
- `imem_rdata`  in  32  instruction word; captured when `imem_rvalid`=1 in FETCH.
- `instr`  out  32  held instruction; `instr[6:0]` drives decoder `op`.
- `instr_valid`  out  1  execute window; datapath gates `Reg_Write`/`Mem_Write` with it.
- `pc`  out  XLEN  address of `instr`.
- `pc_plus4`  out  XLEN  `pc + 4`; the link value for JAL/JALR writeback.
- `branch`, `pc_jal`, `pc_jalr`  in  1 each  decoder controls.
- `zero`  in  1  ALU compare result for the branch condition.
- `imm`  in  XLEN  extended immediate from the immediate extender.
- `alu_result`  in  XLEN  ALU output; the JALR target (rs1+imm).
- `misalign_err`  out  1  sticky: a taken target was not word-aligned; core halted.

## Operation
- FSM states: BOOT, FETCH, EXEC, HALT.
- BOOT: entered on reset. Lasts exactly one cycle, then goes to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_rvalid`=1: `instr` <= `imem_rdata`, go to EXEC. Otherwise stay in FETCH, holding `instr` and `pc`.
- EXEC:
  - `instr_valid`=1 for exactly one cycle and `imem_req`=0.
  - `imem_rvalid` is ignored.
  - At the end of the cycle: `pc` <= `next_pc`, go to FETCH.
- `next_pc` priority:
  1. `pc_jalr` → `{alu_result[XLEN-1:1],1'b0}`.
  2. Otherwise `pc_jal` → `pc+imm`.
  3. Otherwise `branch & zero` → `pc+imm`.
  4. Otherwise `pc+4`.
- Control inputs are don't-care outside EXEC.
- Arithmetic is modulo 2^XLEN; wrap-around from 32'hFFFF_FFFC to 0 is silent.
- Misalignment:
  - Trigger: in EXEC, `next_pc[1:0]`≠0.
  - Response: `pc` is not updated, `misalign_err` <= 1, go to HALT.
- HALT:
  - Absorbing; only `rst_n` exits.
  - `imem_req`=0, `instr_valid`=0, `pc` frozen at the faulting instruction.
- Reset values: state=BOOT, `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `imem_req`=0, `misalign_err`=0.
- Reset mid-fetch: the outstanding request is abandoned. Any `imem_rvalid` that arrives after reset release, before FETCH is re-entered, is ignored.

## Timing
- `imem_req`, `imem_addr`, `instr_valid`, `instr`, `pc` and `misalign_err` are registered or state-decoded only. There is no combinational path from `imem_rvalid` to any output.
- `pc_plus4` is combinational from `pc`.
- Minimum throughput: 2 cycles per instruction (FETCH with `imem_rvalid` in its first cycle, then EXEC).
- Each memory wait cycle adds one cycle.
- First `imem_req` is asserted in the second cycle after `rst_n` deasserts (first cycle is BOOT).
- `next_pc` is sampled only on the EXEC clock edge. The decode→ALU→`next_pc` path must close in one cycle.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (7'd51, 19, 3, 103, 35, 99, 111);
  - `NOP_INSTR` = 32'h0000_0013;
  - state encoding BOOT/FETCH/EXEC/HALT.
- One sub-module, `next_pc_sel`: purely combinational. Computes the target mux, priority and misalignment flag from `pc`, `imm`, `alu_result` and the controls.
- `fetch_unit` holds the FSM and the PC/instruction registers.

## Test plan
- Reset, zero-wait memory, sequential ALU ops at `RESET_PC`=0:
  - `imem_req` rises 2 cycles after `rst_n`;
  - `pc` steps 0,4,8;
  - `instr_valid` pulses every 2nd cycle;
  - `instr` after reset = 32'h13.
- Memory with 3 wait cycles:
  - `imem_req`/`imem_addr` held 4 cycles;
  - `instr` captured only on `rvalid`;
  - one EXEC per instruction.
- Branches at `pc`=0x40 with `imm`=0x20:
  - BEQ taken (`branch`=1, `zero`=1) → next fetch 0x60;
  - not taken (`zero`=0) → 0x44.
- Jumps:
  - JAL at 0x100, `imm`=-8 → next fetch 0xF8, `pc_plus4`=0x104 during EXEC;
  - JALR with `alu_result`=0x201 → next fetch 0x200;
  - JALR and JAL asserted together → JALR target wins.
- JAL with `imm`=0x6 from 0x10:
  - `misalign_err`=1;
  - state HALT, `pc` stays 0x10, no further `imem_req` until reset;
  - asserting `rst_n`=0 clears everything.
- `rst_n` asserted while FETCH waits on memory:
  - all outputs return to reset values asynchronously;
  - a stale `imem_rvalid` during BOOT does not load `instr`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: opcodes, the NOP word and the fetch FSM encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'd51;
  localparam logic [6:0] OP_I_TYPE = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target mux (JALR > JAL > taken branch > pc+4) with word-alignment check.
module next_pc_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch,
  input  logic            zero,
  input  logic            pc_jal,
  input  logic            pc_jalr,
  output logic [XLEN-1:0] next_pc_c,
  output logic            misalign_c
);

  always_comb begin
    next_pc_c = pc + XLEN'(4);
    if (pc_jalr) begin
      next_pc_c = {alu_result[XLEN-1:1], 1'b0};
    end else if (pc_jal || (branch && zero)) begin
      next_pc_c = pc + imm;
    end
    misalign_c = next_pc_c[1] | next_pc_c[0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencing: BOOT -> FETCH (wait on rvalid) -> EXEC -> FETCH, HALT on misaligned target.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            branch,
  input  logic            pc_jal,
  input  logic            pc_jalr,
  input  logic            zero,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            imem_req_q, imem_req_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] next_pc_c;
  logic            misalign_c;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc         (pc_q),
    .imm        (imm),
    .alu_result (alu_result),
    .branch     (branch),
    .zero       (zero),
    .pc_jal     (pc_jal),
    .pc_jalr    (pc_jalr),
    .next_pc_c  (next_pc_c),
    .misalign_c (misalign_c)
  );

  // Outputs are decoded from the next state so they are flops, never paths from imem_rvalid.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    misalign_d    = misalign_q;
    instr_valid_d = 1'b0;
    imem_req_d    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
      end
      ST_FETCH: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ST_EXEC;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (misalign_c) begin
          misalign_d = 1'b1;
          state_d    = ST_HALT;
        end else begin
          pc_d       = next_pc_c;
          imem_req_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + XLEN'(4);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized memory wait states and controls against a PC-sequencing model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch = 1'b0, pc_jal = 1'b0, pc_jalr = 1'b0, zero = 1'b0;
  logic [31:0] imm = '0, alu_result = '0;
  logic        misalign_err;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .branch(branch),
    .pc_jal(pc_jal), .pc_jalr(pc_jalr), .zero(zero), .imm(imm),
    .alu_result(alu_result), .misalign_err(misalign_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit          br;
    bit          z;
    bit          jal;
    bit          jalr;
    logic [31:0] imm;
    logic [31:0] alu;
  } ctrl_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t  exp_q[$];
  ctrl_t dir_q[$];
  int    n_vec = 0, n_err = 0;
  int    fixed_wait = 0;
  bit    drv_en = 1'b0;
  bit    no_mis = 1'b1;
  logic [31:0] pc_m = '0;
  bit    halted_m = 1'b0;
  bit    in_fetch = 1'b0;
  int    wcnt = 0;
  int    n_exec = 0;
  int    cyc = 0;
  int    last_exec = 0;
  bit    have_last = 1'b0;
  ctrl_t cur_c;
  logic [31:0] nxt;
  exp_t  e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Architectural next-PC rule, written directly from the jump/branch priority.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input ctrl_t c);
    if (c.jalr) return c.alu & 32'hFFFF_FFFE;
    if (c.jal) return cur_pc + c.imm;
    if (c.br && c.z) return cur_pc + c.imm;
    return cur_pc + 32'd4;
  endfunction

  function automatic ctrl_t mk(input bit br, input bit z, input bit jal, input bit jalr,
                               input logic [31:0] im, input logic [31:0] alu);
    ctrl_t c;
    c.br = br; c.z = z; c.jal = jal; c.jalr = jalr; c.imm = im; c.alu = alu;
    return c;
  endfunction

  function automatic ctrl_t rand_ctrl();
    ctrl_t c;
    bit mis;
    mis    = !no_mis && ($urandom_range(0, 19) == 0);
    c.br   = 1'($urandom);
    c.z    = 1'($urandom);
    c.jal  = ($urandom_range(0, 3) == 0);
    c.jalr = ($urandom_range(0, 4) == 0);
    c.imm  = $urandom;
    c.alu  = $urandom;
    if (!mis) begin
      c.imm[1:0] = 2'b00;
      c.alu[1]   = 1'b0;
    end
    return c;
  endfunction

  task automatic apply(input ctrl_t c);
    branch = c.br; zero = c.z; pc_jal = c.jal; pc_jalr = c.jalr;
    imm = c.imm; alu_result = c.alu;
  endtask

  // Driver: instruction memory with wait states, plus controls during each execute window.
  initial forever begin
    @(posedge clk);
    #1;
    if (drv_en) begin
      if (imem_req) begin
        chk("imem_addr", imem_addr, pc_m);
        if (!in_fetch) begin
          in_fetch = 1'b1;
          wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        imem_rdata = $urandom;
        if (wcnt == 0) begin
          imem_rvalid = 1'b1;
          exp_q.push_back('{pc_m, imem_rdata});
          in_fetch = 1'b0;
        end else begin
          wcnt--;
          imem_rvalid = 1'b0;
        end
      end else begin
        imem_rvalid = 1'($urandom);
        imem_rdata  = $urandom;
      end
      if (instr_valid) begin
        cur_c = (dir_q.size() != 0) ? dir_q.pop_front() : rand_ctrl();
        apply(cur_c);
        nxt = model_next(pc_m, cur_c);
        if (nxt[1:0] != 2'b00) halted_m = 1'b1;
        else pc_m = nxt;
      end else begin
        apply(rand_ctrl());
      end
    end
  end

  // Monitor: every execute window must match the oldest fetched instruction.
  initial forever begin
    @(posedge clk);
    #3;
    cyc++;
    if (rst_n && instr_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL exec_unexpected: got instr_valid at pc %h expected no execute window", pc);
      end else begin
        e = exp_q.pop_front();
        chk("instr", instr, e.instr);
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("misalign_err_run", {31'b0, misalign_err}, 32'd0);
      end
      if (fixed_wait >= 0 && have_last)
        chk("exec_spacing", 32'(cyc - last_exec), 32'(fixed_wait + 2));
      have_last = 1'b1;
      last_exec = cyc;
      n_exec++;
    end
  end

  task automatic do_reset(input bit stale);
    drv_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    exp_q.delete();
    dir_q.delete();
    pc_m = 32'h0; halted_m = 1'b0; in_fetch = 1'b0; wcnt = 0; have_last = 1'b0;
    imem_rvalid = stale;
    imem_rdata  = 32'hDEAD_BEEF;
    apply(mk(0, 0, 0, 0, 32'h0, 32'h0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("boot_imem_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    #2;
    chk("first_imem_req", {31'b0, imem_req}, 32'd1);
    chk("boot_instr", instr, NOP);
    chk("boot_instr_valid", {31'b0, instr_valid}, 32'd0);
    imem_rvalid = 1'b0;
    drv_en = 1'b1;
  endtask

  task automatic run_instrs(input int n, input int budget);
    int start = n_exec;
    int c = 0;
    while ((n_exec - start) < n && !halted_m && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (c >= budget) fail_now("run_timeout");
  endtask

  task automatic halt_checks(input logic [31:0] pc_exp);
    @(posedge clk);
    #2;
    repeat (6) begin
      chk("halt_imem_req", {31'b0, imem_req}, 32'd0);
      chk("halt_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("halt_misalign", {31'b0, misalign_err}, 32'd1);
      chk("halt_pc", pc, pc_exp);
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int c;
    @(posedge clk);
    #2;

    // Zero-wait memory: sequential steps, branches, jumps and JAL/JALR priority.
    fixed_wait = 0;
    no_mis = 1'b1;
    do_reset(1'b0);
    dir_q.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0));
    dir_q.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0));
    dir_q.push_back(mk(0, 0, 0, 1, 32'h0, 32'h41));
    dir_q.push_back(mk(1, 1, 0, 0, 32'h20, 32'h0));
    dir_q.push_back(mk(0, 0, 0, 1, 32'h0, 32'h41));
    dir_q.push_back(mk(1, 0, 0, 0, 32'h20, 32'h0));
    dir_q.push_back(mk(0, 0, 0, 1, 32'h0, 32'h100));
    dir_q.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFF8, 32'h0));
    dir_q.push_back(mk(0, 0, 1, 1, 32'h40, 32'h201));
    run_instrs(12, 200);

    // Three wait cycles per fetch, then reset while a fetch is outstanding.
    fixed_wait = 3;
    @(posedge clk);
    #2;
    do_reset(1'b0);
    run_instrs(8, 200);
    c = 0;
    while (!(imem_req && in_fetch && wcnt > 0) && c < 20) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (c >= 20) fail_now("midfetch_wait");
    chk("midfetch_req", {31'b0, imem_req}, 32'd1);
    do_reset(1'b1);
    run_instrs(3, 100);

    // Misaligned JAL target halts with pc frozen at the faulting instruction.
    fixed_wait = 0;
    @(posedge clk);
    #2;
    do_reset(1'b0);
    dir_q.push_back(mk(0, 0, 0, 1, 32'h0, 32'h10));
    dir_q.push_back(mk(0, 0, 1, 0, 32'h6, 32'h0));
    run_instrs(10, 200);
    halt_checks(32'h10);

    // Randomized episodes with random wait states and occasional misaligned targets.
    fixed_wait = -1;
    no_mis = 1'b0;
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(1'(ep % 2));
      run_instrs(60, 1200);
      if (halted_m) halt_checks(pc_m);
      @(posedge clk);
      #2;
    end
    do_reset(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
